// File: rtl/xbus_arbiter.sv
// xbus_arbiter: XBus round-robin arbiter and address/data phase sequencer.
// Optional sig_wait watchdog compiled in with XBUS_ARB_WATCHDOG_EN.
module xbus_arbiter #(
  parameter int NUM_MASTERS     = 16,
  parameter int MAX_WAIT_CYCLES = 16
) (
  input  logic        sig_clock,
  input  logic        sig_reset,
  input  logic [15:0] sig_request,
  input  logic        sig_read,
  input  logic        sig_write,
  input  logic        sig_bip,
  input  logic        sig_wait,
  input  logic        sig_error,
  output logic        sig_start,
  output logic [15:0] sig_grant,
  output logic [3:0]  grant_id,
  output logic        busy,
  output logic        timeout
);
  typedef enum logic [1:0] {RST_IDLE, ARB, ADDR, DATA} state_t;
  localparam logic [15:0] MASK = 16'((33'd1 << NUM_MASTERS) - 33'd1);
  state_t      r_state;
  logic [3:0]  r_ptr;
  logic [3:0]  w_win;
  logic [4:0]  w_k;
  logic [15:0] w_req;
  logic        w_done;
  logic        w_to;
  assign w_req  = sig_request & MASK;
  assign w_done = !sig_wait && (sig_error || !sig_bip);
  // Scan downward so the last hit is the first requester after the pointer.
  always_comb begin
    w_win = r_ptr;
    w_k   = 5'd0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      w_k   = {1'b0, r_ptr} + 5'(i);
      w_k   = (w_k >= 5'(NUM_MASTERS)) ? w_k - 5'(NUM_MASTERS) : w_k;
      w_win = w_req[w_k[3:0]] ? w_k[3:0] : w_win;
    end
  end
`ifdef XBUS_ARB_WATCHDOG_EN
  localparam int WW = $clog2(MAX_WAIT_CYCLES + 1);
  logic [WW-1:0] r_wcnt;
  assign w_to = (r_state == DATA) && sig_wait && (r_wcnt == WW'(MAX_WAIT_CYCLES - 1));
  always_ff @(posedge sig_clock or posedge sig_reset) begin
    if (sig_reset) r_wcnt <= '0;
    else r_wcnt <= (r_state == DATA && sig_wait && !w_to) ? r_wcnt + WW'(1) : '0;
  end
`else
  // Watchdog absent: constant 0, still referencing its limit parameter.
  assign w_to = (MAX_WAIT_CYCLES < 0);
`endif
  always_ff @(posedge sig_clock or posedge sig_reset) begin
    if (sig_reset) begin
      r_state   <= RST_IDLE;
      r_ptr     <= 4'(NUM_MASTERS - 1);
      sig_start <= 1'b0;
      sig_grant <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= w_to;
      case (r_state)
        RST_IDLE: begin
          r_state   <= ARB;
          sig_start <= 1'b1;
        end
        ARB: if (|w_req) begin
          r_state   <= ADDR;
          r_ptr     <= w_win;
          grant_id  <= w_win;
          sig_grant <= 16'd1 << w_win;
          sig_start <= 1'b0;
          busy      <= 1'b1;
        end
        ADDR: begin
          sig_grant <= '0;
          if (sig_read || sig_write) r_state <= DATA;
          else begin
            r_state   <= ARB;
            sig_start <= 1'b1;
            busy      <= 1'b0;
          end
        end
        DATA: if (w_done || w_to) begin
          r_state   <= ARB;
          sig_start <= 1'b1;
          busy      <= 1'b0;
        end
        default: r_state <= RST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xbus_arbiter.sv
// tb_xbus_arbiter: directed checks of arbitration, phase sequencing and reset.
module tb_xbus_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        rd, wr, bip, wt, err;
  logic        sig_start, busy, timeout;
  logic [15:0] sig_grant;
  logic [3:0]  grant_id;
  int          n_pass = 0;
  int          n_total = 0;
  logic [3:0]  rr_exp [5] = '{4'd0, 4'd5, 4'd10, 4'd15, 4'd0};

  always #5 clk = ~clk;

  xbus_arbiter #(.NUM_MASTERS(16), .MAX_WAIT_CYCLES(4)) dut (
    .sig_clock(clk), .sig_reset(rst), .sig_request(req), .sig_read(rd), .sig_write(wr),
    .sig_bip(bip), .sig_wait(wt), .sig_error(err), .sig_start(sig_start),
    .sig_grant(sig_grant), .grant_id(grant_id), .busy(busy), .timeout(timeout)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = '0; rd = 0; wr = 0; bip = 0; wt = 0; err = 0;
    repeat (3) tick();
    n_total++; if ({sig_start, busy, timeout} !== 3'b000) $display("FAIL rst_flags got=%b exp=000", {sig_start, busy, timeout}); else n_pass++;
    n_total++; if (sig_grant !== 16'h0) $display("FAIL rst_grant got=%h exp=0000", sig_grant); else n_pass++;
    n_total++; if (grant_id !== 4'd0) $display("FAIL rst_id got=%0d exp=0", grant_id); else n_pass++;
    rst = 1'b0;
    tick();
    n_total++; if (sig_start !== 1'b1) $display("FAIL rel_start got=%b exp=1", sig_start); else n_pass++;
    repeat (2) tick();
    n_total++; if ({sig_start, busy, sig_grant} !== {2'b10, 16'h0}) $display("FAIL idle_arb got=%b/%b/%h exp=1/0/0000", sig_start, busy, sig_grant); else n_pass++;
  endtask

  task automatic test_round_robin_nop;
    req = 16'h8421; rd = 0; wr = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_total++; if (grant_id !== rr_exp[i]) $display("FAIL rr_id[%0d] got=%0d exp=%0d", i, grant_id, rr_exp[i]); else n_pass++;
      n_total++; if (sig_grant !== (16'd1 << rr_exp[i])) $display("FAIL rr_grant[%0d] got=%h exp=%h", i, sig_grant, 16'd1 << rr_exp[i]); else n_pass++;
      n_total++; if ({busy, sig_start} !== 2'b10) $display("FAIL rr_addr[%0d] busy/start got=%b exp=10", i, {busy, sig_start}); else n_pass++;
      tick();
      n_total++; if ({busy, sig_start, sig_grant} !== {2'b01, 16'h0}) $display("FAIL nop_arb[%0d] got=%b/%b/%h exp=0/1/0000", i, busy, sig_start, sig_grant); else n_pass++;
    end
  endtask

  task automatic test_single_write;
    req = 16'h0001; wr = 1; rd = 0; bip = 0; wt = 0; err = 0;
    tick();
    n_total++; if ({sig_grant, grant_id} !== {16'h0001, 4'd0}) $display("FAIL sw_addr got=%h/%0d exp=0001/0", sig_grant, grant_id); else n_pass++;
    req = 16'h0;
    tick();
    n_total++; if ({busy, sig_start, sig_grant} !== {2'b10, 16'h0}) $display("FAIL sw_data got=%b/%b/%h exp=1/0/0000", busy, sig_start, sig_grant); else n_pass++;
    tick();
    n_total++; if ({busy, sig_start} !== 2'b01) $display("FAIL sw_end busy/start got=%b exp=01", {busy, sig_start}); else n_pass++;
  endtask

  task automatic test_burst;
    logic [5:0] wv = 6'b000110;
    logic [5:0] bv = 6'b011111;
    req = 16'h0002; wr = 1; rd = 0; bip = 1; wt = 0; err = 0;
    tick();
    n_total++; if ({sig_grant, grant_id} !== {16'h0002, 4'd1}) $display("FAIL bu_addr got=%h/%0d exp=0002/1", sig_grant, grant_id); else n_pass++;
    req = 16'hFFFF;
    tick();
    for (int j = 0; j < 6; j++) begin
      wt = wv[j]; bip = bv[j];
      n_total++; if ({busy, sig_start, sig_grant} !== {2'b10, 16'h0}) $display("FAIL bu_data[%0d] got=%b/%b/%h exp=1/0/0000", j, busy, sig_start, sig_grant); else n_pass++;
      tick();
    end
    req = 16'h0;
    n_total++; if ({busy, sig_start} !== 2'b01) $display("FAIL bu_end busy/start got=%b exp=01", {busy, sig_start}); else n_pass++;
  endtask

  task automatic test_error;
    req = 16'h0002; rd = 1; wr = 0; bip = 1; wt = 1; err = 1;
    tick();
    n_total++; if ({sig_grant, grant_id} !== {16'h0002, 4'd1}) $display("FAIL er_regrant got=%h/%0d exp=0002/1", sig_grant, grant_id); else n_pass++;
    req = 16'h0;
    tick();
    tick();
    n_total++; if ({busy, sig_start} !== 2'b10) $display("FAIL er_wait busy/start got=%b exp=10", {busy, sig_start}); else n_pass++;
    wt = 0;
    tick();
    n_total++; if ({busy, sig_start} !== 2'b01) $display("FAIL er_abort busy/start got=%b exp=01", {busy, sig_start}); else n_pass++;
    err = 0;
  endtask

  task automatic test_reset_mid;
    req = 16'h0004; rd = 1; wr = 0; bip = 0; wt = 0;
    tick();
    n_total++; if (sig_grant !== 16'h0004) $display("FAIL rm_addr got=%h exp=0004", sig_grant); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if ({sig_start, busy, timeout, sig_grant, grant_id} !== 23'h0) $display("FAIL rm_async got=%b/%b/%b/%h/%0d exp=0/0/0/0000/0", sig_start, busy, timeout, sig_grant, grant_id); else n_pass++;
    tick();
    req = 16'h0;
    rst = 1'b0;
    tick();
    n_total++; if ({sig_start, busy, sig_grant} !== {2'b10, 16'h0}) $display("FAIL rm_arb got=%b/%b/%h exp=1/0/0000", sig_start, busy, sig_grant); else n_pass++;
  endtask

`ifdef XBUS_ARB_WATCHDOG_EN
  task automatic test_watchdog;
    req = 16'h0001; wr = 1; rd = 0; wt = 1; bip = 1;
    tick();
    n_total++; if (sig_grant !== 16'h0001) $display("FAIL wd_addr got=%h exp=0001", sig_grant); else n_pass++;
    req = 16'h0;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_total++; if ({busy, timeout} !== 2'b10) $display("FAIL wd_wait[%0d] busy/timeout got=%b exp=10", i, {busy, timeout}); else n_pass++;
      tick();
    end
    n_total++; if ({timeout, sig_start, busy} !== 3'b110) $display("FAIL wd_fire got=%b exp=110", {timeout, sig_start, busy}); else n_pass++;
    wt = 0;
    tick();
    n_total++; if ({timeout, sig_start} !== 2'b01) $display("FAIL wd_pulse got=%b exp=01", {timeout, sig_start}); else n_pass++;
  endtask
`else
  task automatic test_long_wait;
    req = 16'h0001; wr = 1; rd = 0; wt = 1; bip = 0;
    tick();
    req = 16'h0;
    tick();
    repeat (20) tick();
    n_total++; if ({busy, sig_start, timeout} !== 3'b100) $display("FAIL lw_hold got=%b exp=100", {busy, sig_start, timeout}); else n_pass++;
    wt = 0;
    tick();
    n_total++; if ({busy, sig_start, timeout} !== 3'b010) $display("FAIL lw_end got=%b exp=010", {busy, sig_start, timeout}); else n_pass++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL time_limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin_nop();
    test_single_write();
    test_burst();
    test_error();
    test_reset_mid();
`ifdef XBUS_ARB_WATCHDOG_EN
    test_watchdog();
`else
    test_long_wait();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
